// File: rtl/mio_uart_tx.sv
// MIO-bus UART transmitter: byte FIFO fed by CPU stores, 8N1 serialiser on txd, pollable status word.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mio_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr_ovf,
    output logic        txd,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic [31:0] status
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = (FIFO_AW)'(1);
    localparam logic [15:0]        BAUD_LAST  = 16'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PARITY_BUILD = 1'b1;
`else
    localparam logic       PARITY_BUILD = 1'b0;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               ovf_reg;

    logic [2:0]  state_reg, state_next;
    logic [15:0] baud_reg, baud_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  sr_reg, sr_next;
    logic        txd_reg, txd_next;
`ifdef UART_TX_PARITY_EN
    logic        par_reg, par_next;
`endif

    logic       pop;
    logic       push;
    logic       drop;
    logic       bit_done;
    logic [7:0] head;
    logic [4:0] count5;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == COUNT_FULL);
    assign busy     = (state_reg != S_IDLE);
    assign txd      = txd_reg;
    assign bit_done = (baud_reg == BAUD_LAST);

    // The head is read asynchronously so the IDLE cycle can load it into sr on the same edge as the pop.
    assign head = mem[rd_ptr_reg];
    assign pop  = (state_reg == S_IDLE) && !empty;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    generate
        if (FIFO_AW >= 4) begin : g_cnt_trim
            assign count5 = count_reg[4:0];
        end else begin : g_cnt_ext
            assign count5 = {{(4 - FIFO_AW){1'b0}}, count_reg};
        end
    endgenerate

    assign status = {16'b0, PARITY_BUILD, 2'b0, count5, 5'b0, ovf_reg, full, busy};

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        sr_next    = sr_reg;
`ifdef UART_TX_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_START;
                    baud_next  = '0;
                    sr_next    = head;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_next = '0;
                    sr_next   = {1'b0, sr_reg[7:1]};
                    bit_next  = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
            end
        endcase

        // txd is registered, so it is decoded from where the FSM will be after this edge.
        txd_next = 1'b1;
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = sr_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_next = par_next;
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            sr_reg     <= '0;
            txd_reg    <= 1'b1;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            sr_reg    <= sr_next;
            txd_reg   <= txd_next;
`ifdef UART_TX_PARITY_EN
            par_reg   <= par_next;
`endif
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A dropped write outranks a simultaneous clear.
            if (drop)         ovf_reg <= 1'b1;
            else if (clr_ovf) ovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: tb/tb_mio_uart_tx.sv
// Directed bench for mio_uart_tx: scoreboard of accepted bytes checked against frames decoded from txd.
module tb_mio_uart_tx;

    localparam int B   = 4;
    localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS     = 11;
    localparam logic [31:0] STAT_BASE = 32'h0000_8000;
`else
    localparam int          NBITS     = 10;
    localparam logic [31:0] STAT_BASE = 32'h0000_0000;
`endif
    localparam int STOP_MID = (NBITS - 1) * B + B / 2;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_ovf;
    logic        txd;
    logic        busy;
    logic        full;
    logic        empty;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_start = -1;
    int frames_seen = 0;
    logic [7:0] sb [$];

    mio_uart_tx #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
        .clk(clk), .RSTN(rstn), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .txd(txd), .busy(busy), .full(full), .empty(empty), .status(status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Frame decoder: samples txd mid-bit, 2 time units after each rising edge.
    initial begin
        bit         in_frame = 1'b0;
        int         cnt = 0;
        int         idx;
        logic [7:0] rx = '0;
        logic       par = 1'b0;
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            #2;
            if (!rstn) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (txd === 1'b0) begin
                    in_frame   = 1'b1;
                    cnt        = 0;
                    last_start = cyc;
                end
            end else begin
                cnt++;
                if (cnt == B / 2) chk("mon_start_bit", txd, 1'b0);
                if (cnt >= B + B / 2 && cnt < 9 * B && ((cnt - B - B / 2) % B) == 0) begin
                    idx = (cnt - B - B / 2) / B;
                    rx[idx] = txd;
                end
                if (cnt == 9 * B + B / 2) par = txd;
                if (cnt == STOP_MID) begin
                    chk("mon_stop_bit", txd, 1'b1);
                    chk("mon_frame_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        chk("mon_data", rx, exp_b);
`ifdef UART_TX_PARITY_EN
                        chk("mon_parity", par, ^exp_b);
`endif
                    end
                    $display("frame %0d: rx=%02h at start cycle %0d", frames_seen, rx, last_start);
                    frames_seen++;
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        int         t;
        int         s1;
        int         f0;
        bit         found;
        logic [7:0] a5;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Reset then idle
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_txd", txd, 1'b1);
            chk("idle_empty", empty, 1'b1);
            chk("idle_status", status, STAT_BASE);
        end
        $display("reset/idle: 50 cycles observed");

        // Single byte with exact bit timing
        a5 = 8'hA5;
        do_write(a5);
        sb.push_back(a5);
        t = cyc;
        chk("single_pre_busy", busy, 1'b0);
        chk("single_pre_empty", empty, 1'b0);
        chk("single_pre_txd", txd, 1'b1);
        @(negedge clk);
        chk("single_start_cycle", last_start, t + 1);
        chk("single_busy", busy, 1'b1);
        chk("single_empty_after_pop", empty, 1'b1);
        chk("single_start_txd", txd, 1'b0);
        for (int c = 2; c <= B; c++) begin
            @(negedge clk);
            chk("single_start_txd", txd, 1'b0);
        end
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < B; c++) begin
                @(negedge clk);
                chk("single_data_txd", txd, a5[b]);
            end
        end
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < B; c++) begin
            @(negedge clk);
            chk("single_parity_txd", txd, 1'b0);
        end
`endif
        for (int c = 0; c < B; c++) begin
            @(negedge clk);
            chk("single_stop_txd", txd, 1'b1);
            chk("single_stop_busy", busy, 1'b1);
        end
        @(negedge clk);
        chk("single_busy_fall", busy, 1'b0);
        chk("single_busy_fall_cycle", cyc, t + NBITS * B + 1);
        $display("single byte A5: busy fell at cycle %0d (write at %0d)", cyc, t);

        // Back-to-back
        @(negedge clk);
        do_write(8'h00);
        do_write(8'hFF);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        s1 = last_start;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (last_start != s1) begin
                found = 1'b1;
                break;
            end
            chk("b2b_second_queued", empty, 1'b0);
        end
        chk("b2b_second_start_seen", found, 1'b1);
        chk("b2b_gap", last_start - s1, NBITS * B + 1);
        chk("b2b_empty_after_pop", empty, 1'b1);
        chk("b2b_txd_start", txd, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        chk("b2b_done", found, 1'b1);
        $display("back-to-back 00/FF: second start %0d cycles after first", last_start - s1);

        // Overflow with depth 4
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            do_write(8'h11 + 8'(i));
            if (i < 5) sb.push_back(8'h11 + 8'(i));
        end
        chk("ovf_full", full, 1'b1);
        chk("ovf_status", status, STAT_BASE | 32'h0000_0407);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", status[2], 1'b1);
        chk("ovf_count_after_drop", status[12:8], 5'd4);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", status[2], 1'b0);
        chk("ovf_still_full", full, 1'b1);
        $display("overflow: status=%08h after clr_ovf", status);

        // Write and pop together while full, on the IDLE cycle
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        chk("wp_idle_seen", found, 1'b1);
        chk("wp_full_before", full, 1'b1);
        do_write(8'h17);
        sb.push_back(8'h17);
        chk("wp_count", status[12:8], 5'd4);
        chk("wp_full_after", full, 1'b1);
        chk("wp_ovf", status[2], 1'b0);
        chk("wp_busy", busy, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (empty && !busy) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_done", found, 1'b1);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_frames", frames_seen, 9);
        $display("write+pop while full: drained, frames=%0d", frames_seen);

        // Reset during DATA bit 3 with bytes queued
        @(negedge clk);
        do_write(8'h21);
        do_write(8'h22);
        do_write(8'h23);
        s1 = last_start;
        chk("rst_frame_started", s1, cyc - 1);
        repeat (15) @(negedge clk);
        chk("rst_pre_bit3", txd, 1'b0);
        chk("rst_pre_queued", empty, 1'b0);
        f0 = frames_seen;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_status", status, STAT_BASE);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("rst_no_restart", txd, 1'b1);
        end
        chk("rst_no_frame", frames_seen, f0);
        chk("rst_last_start", last_start, s1);
        chk("final_sb_empty", sb.size(), 0);
        $display("reset mid-frame: line idle for 60 cycles");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
